// File: rtl/reg_dump_reader.sv
// reg_dump_reader: read-side sequencer for the register file.
// After a start pulse it walks addresses 0..DEPTH-1. For each address it
// samples the combinational read data and streams the value out over a
// valid/ready handshake. It never writes the register file.
// Build option: define REG_DUMP_CHECKSUM_EN to append one extra word after
// the data words. That word carries the XOR of all data words, with addr 0
// and the last flag set.
module reg_dump_reader #(
  parameter int SIZE   = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_start,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [SIZE-1:0]   i_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [SIZE-1:0]   o_out_data,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_out_last,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // S_CSUM is only entered when the checksum word is built in.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_CSUM  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [SIZE-1:0]   r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [SIZE-1:0]   r_acc;
`endif

  logic w_handshake;
  logic w_at_last_addr;

  assign w_handshake    = r_out_valid && i_out_ready;
  assign w_at_last_addr = (r_rd_addr == LAST_ADDR);

  // Dump sequencer: address walk, output word register, busy/done flags.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_rd_addr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_acc       <= '0;
`endif
    end else begin
      // done is a single-cycle pulse; it is raised only on the final handshake.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
            r_acc     <= '0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FETCH: begin
          // The read mux had a full cycle to settle on r_rd_addr.
          r_out_data  <= i_rd_data;
          r_out_addr  <= r_rd_addr;
          r_out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          r_out_last  <= 1'b0;
          r_acc       <= r_acc ^ i_rd_data;
`else
          r_out_last  <= w_at_last_addr;
`endif
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
`ifdef REG_DUMP_CHECKSUM_EN
            end else if (w_at_last_addr) begin
              // The data walk is finished, but the checksum word is still owed.
              r_state <= S_CSUM;
`endif
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
              r_state   <= S_FETCH;
            end
          end else begin
            // Hold the word stable until the consumer takes it.
            r_state <= S_SEND;
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        S_CSUM: begin
          r_out_data  <= r_acc;
          r_out_addr  <= '0;
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b1;
          r_state     <= S_SEND;
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_rd_addr   = r_rd_addr;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;
  assign o_out_last  = r_out_last;
  assign o_done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Testbench for reg_dump_reader: models the register file, predicts each dump
// from the register contents and checks the output stream in a monitor.
module tb_reg_dump_reader;
  localparam int SIZE   = 4;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {
    logic [SIZE-1:0]   data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } word_t;

  logic              clk;
  logic              clr;
  logic              i_start;
  logic              o_busy;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [SIZE-1:0]   i_rd_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [SIZE-1:0]   o_out_data;
  logic [ADDR_W-1:0] o_out_addr;
  logic              o_out_last;
  logic              o_done;

  logic [SIZE-1:0] regs [DEPTH];
  word_t           exp_q [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_edge = 0;
  bit prev_done = 1'b0;

  reg_dump_reader #(.SIZE(SIZE), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .clr(clr), .i_start(i_start), .o_busy(o_busy),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_addr(o_out_addr),
    .o_out_last(o_out_last), .o_done(o_done)
  );

  // Register file read mux: combinational lookup.
  assign i_rd_data = regs[o_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample on the falling edge and pop the expected word on each handshake.
  always @(negedge clk) begin
    if (clr) begin
      if (o_out_valid && i_out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got data=%0h addr=%0h last=%0b with nothing expected",
                   o_out_data, o_out_addr, o_out_last);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word", 32'({o_out_data, o_out_addr, o_out_last}), 32'(w));
        end
      end
      if (o_done) begin
        done_cnt++;
        done_edge = cyc;
        chk("done_busy_low", 32'(o_busy), 32'd0);
        chk("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = o_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Reference model: the dump is every register in address order, then the optional XOR word.
  task automatic push_expected();
    word_t w;
    logic [SIZE-1:0] acc;
    acc = '0;
    for (int a = 0; a < DEPTH; a++) begin
      acc    = acc ^ regs[a];
      w.data = regs[a];
      w.addr = ADDR_W'(a);
      w.last = (a == DEPTH - 1) && !CSUM;
      exp_q.push_back(w);
    end
    if (CSUM) begin
      w.data = acc;
      w.addr = '0;
      w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic run_dump(input int stall_addr, input int stall_len, input int busy_start_addr,
                          input bit rnd_ready, input bit chk_timing);
    int d0;
    int stalled;
    int start_edge;
    bit bs_done;
    d0 = done_cnt;
    stalled = 0;
    bs_done = 1'b0;
    push_expected();
    i_start = 1'b1;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    start_edge = cyc;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    for (int c = 0; c < 400; c++) begin
      if (done_cnt != d0) break;
      i_start = 1'b0;
      if (stall_addr >= 0 && stalled < stall_len && o_out_valid && int'(o_out_addr) == stall_addr) begin
        i_out_ready = 1'b0;
        stalled++;
        chk("stall_valid", 32'(o_out_valid), 32'd1);
        chk("stall_data", 32'(o_out_data), 32'(regs[stall_addr]));
        chk("stall_addr", 32'(o_out_addr), 32'(stall_addr));
      end else begin
        i_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (busy_start_addr >= 0 && !bs_done && o_out_valid && int'(o_out_addr) == busy_start_addr) begin
        i_start = 1'b1;
        bs_done = 1'b1;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_out_ready = 1'b1;
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
    if (chk_timing) chk("done_latency", 32'(done_edge - start_edge), 32'(2 * DEPTH + (CSUM ? 2 : 0)));
    if (stall_len > 0) chk("stall_cycles", 32'(stalled), 32'(stall_len));
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_valid", 32'(o_out_valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int h0;
    int d0;
    clr = 1'b1;
    i_start = 1'b0;
    i_out_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) regs[a] = SIZE'(a + 1);

    // Asynchronous reset mid-cycle, before any clock edge.
    #3 clr = 1'b0;
    #1;
    chk("reset_outputs", 32'({o_busy, o_rd_addr, o_out_valid, o_out_data, o_out_addr, o_out_last, o_done}), 32'd0);
    repeat (2) @(posedge clk);
    #3 clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_outputs", 32'({o_busy, o_rd_addr, o_out_valid, o_out_data, o_out_addr, o_out_last, o_done}), 32'd0);
    chk("post_reset_no_done", 32'(done_cnt), 32'd0);

    // Basic dump, then backpressure on word 3, then start while busy.
    run_dump(-1, 0, -1, 1'b0, 1'b1);
    run_dump(3, 5, -1, 1'b0, 1'b0);
    run_dump(-1, 0, 2, 1'b0, 1'b1);

    // Abort after word 4 is accepted.
    h0 = hs_cnt;
    d0 = done_cnt;
    push_expected();
    i_start = 1'b1;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (hs_cnt - h0 >= 5) break;
      @(posedge clk); #1;
    end
    chk("abort_words_before", 32'(hs_cnt - h0), 32'd5);
    #2 clr = 1'b0;
    #1;
    chk("abort_outputs", 32'({o_busy, o_rd_addr, o_out_valid, o_out_data, o_out_addr, o_out_last, o_done}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_idle_outputs", 32'({o_busy, o_out_valid, o_done}), 32'd0);
    run_dump(-1, 0, -1, 1'b0, 1'b1);

    // Random register contents with random consumer backpressure.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < DEPTH; a++) regs[a] = SIZE'($urandom);
      run_dump((r == 1) ? 5 : -1, (r == 1) ? 3 : 0, (r == 2) ? 6 : -1, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
